// File: rtl/fifo_core_ext.sv
// Single-clock circular FIFO with arbitrary depth, almost-full/empty thresholds,
// sticky overflow/underflow flags and synchronous flush. Define FIFO_FWFT_EN for first-word-fall-through output.
module fifo_core_ext #(
   parameter int DEPTH         = 16,
   parameter int WIDTH         = 8,
   parameter int POINTER_WIDTH = 4,
   parameter int AF_THRESH     = 14,
   parameter int AE_THRESH     = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [WIDTH-1:0]         input_data,
   output logic [WIDTH-1:0]         output_data,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [POINTER_WIDTH:0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam logic [POINTER_WIDTH:0]   CNT_FULL = (POINTER_WIDTH+1)'(DEPTH);
   localparam logic [POINTER_WIDTH:0]   CNT_AF   = (POINTER_WIDTH+1)'(AF_THRESH);
   localparam logic [POINTER_WIDTH:0]   CNT_AE   = (POINTER_WIDTH+1)'(AE_THRESH);
   localparam logic [POINTER_WIDTH:0]   CNT_ONE  = (POINTER_WIDTH+1)'(1);
   localparam logic [POINTER_WIDTH-1:0] PTR_LAST = POINTER_WIDTH'(DEPTH-1);
   localparam logic [POINTER_WIDTH-1:0] PTR_ONE  = POINTER_WIDTH'(1);

   logic [WIDTH-1:0]         mem [DEPTH];
   logic [POINTER_WIDTH-1:0] wr_ptr, rd_ptr;
   logic                     rd_acc, wr_acc;

   assign full         = (count == CNT_FULL);
   assign empty        = (count == '0);
   assign almost_full  = (count >= CNT_AF);
   assign almost_empty = (count <= CNT_AE);

   // A flush cycle swallows both requests, so gating here keeps memory and output untouched.
   assign rd_acc = rd_en & ~empty & ~clear;
   assign wr_acc = wr_en & (~full | rd_acc) & ~clear;

   function automatic logic [POINTER_WIDTH-1:0] ptr_next(input logic [POINTER_WIDTH-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_ONE;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (wr_en & ~wr_acc) overflow  <= 1'b1;
         if (rd_en & ~rd_acc) underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= input_data;
   end

`ifdef FIFO_FWFT_EN
   assign output_data = empty ? '0 : mem[rd_ptr];
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      output_data <= '0;
      else if (rd_acc) output_data <= mem[rd_ptr];
   end
`endif

endmodule

// File: tb/tb_fifo_core_ext.sv
// Scoreboard bench for fifo_core_ext: a 16-deep and a 10-deep instance share one stimulus
// stream; a queue-based model predicts each edge and a monitor compares after every posedge.
module tb_fifo_core_ext;

   typedef logic [7:0] q_t [$];
   typedef struct packed {
      logic [7:0] data;
      logic [4:0] cnt;
      logic       ovf, udf, full, empty, af, ae;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [7:0] input_data = '0;

   logic [7:0] d0, d1;
   logic [4:0] c0, c1;
   logic       f0, e0, af0, ae0, ov0, ud0;
   logic       f1, e1, af1, ae1, ov1, ud1;

   int total = 0;
   int bad   = 0;

   q_t         mq0, mq1;
   logic       mov0, mud0, mov1, mud1;
   logic [7:0] mor0, mor1;
   exp_t       sb0 [$];
   exp_t       sb1 [$];
   exp_t       x0, x1;

   always #5 clk = ~clk;

   fifo_core_ext #(.DEPTH(16), .WIDTH(8), .POINTER_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2)) u_dut16 (
      .clk(clk), .reset(rst_n), .clear(clear), .wr_en(wr_en), .rd_en(rd_en),
      .input_data(input_data), .output_data(d0), .full(f0), .empty(e0),
      .almost_full(af0), .almost_empty(ae0), .count(c0), .overflow(ov0), .underflow(ud0));

   fifo_core_ext #(.DEPTH(10), .WIDTH(8), .POINTER_WIDTH(4), .AF_THRESH(8), .AE_THRESH(3)) u_dut10 (
      .clk(clk), .reset(rst_n), .clear(clear), .wr_en(wr_en), .rd_en(rd_en),
      .input_data(input_data), .output_data(d1), .full(f1), .empty(e1),
      .almost_full(af1), .almost_empty(ae1), .count(c1), .overflow(ov1), .underflow(ud1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic cmp(input string tag, input exp_t e, input logic [7:0] d, input logic [4:0] c,
                      input logic f, em, af, ae, ov, ud);
      chk({tag, ".data"},  32'(d),  32'(e.data));
      chk({tag, ".count"}, 32'(c),  32'(e.cnt));
      chk({tag, ".full"},  32'(f),  32'(e.full));
      chk({tag, ".empty"}, 32'(em), 32'(e.empty));
      chk({tag, ".afull"}, 32'(af), 32'(e.af));
      chk({tag, ".aempt"}, 32'(ae), 32'(e.ae));
      chk({tag, ".ovf"},   32'(ov), 32'(e.ovf));
      chk({tag, ".udf"},   32'(ud), 32'(e.udf));
   endtask

   // Model: the FIFO is just a queue; accept rules come straight from occupancy.
   task automatic step(ref q_t q, ref logic ov, ref logic ud, ref logic [7:0] oreg,
                       input int dep, input logic c, w, r, input logic [7:0] d);
      bit ra, wa;
      if (c) begin
         q.delete();
         ov = 1'b0;
         ud = 1'b0;
      end else begin
         ra = r && (q.size() != 0);
         wa = w && ((q.size() < dep) || ra);
         if (ra) oreg = q.pop_front();
         if (wa) q.push_back(d);
         if (w && !wa) ov = 1'b1;
         if (r && !ra) ud = 1'b1;
      end
   endtask

   function automatic exp_t mk(input q_t q, input logic ov, ud, input logic [7:0] oreg,
                               input int dep, af, ae);
      exp_t e;
      int   n = q.size();
`ifdef FIFO_FWFT_EN
      e.data  = (n != 0) ? q[0] : 8'h00;
`else
      e.data  = oreg;
`endif
      e.cnt   = 5'(n);
      e.ovf   = ov;
      e.udf   = ud;
      e.full  = (n == dep);
      e.empty = (n == 0);
      e.af    = (n >= af);
      e.ae    = (n <= ae);
      return e;
   endfunction

   task automatic model_reset();
      mq0.delete(); mq1.delete();
      mov0 = 0; mud0 = 0; mor0 = '0;
      mov1 = 0; mud1 = 0; mor1 = '0;
   endtask

   task automatic cyc(input logic c, w, r, input logic [7:0] d);
      @(negedge clk);
      clear = c; wr_en = w; rd_en = r; input_data = d;
      step(mq0, mov0, mud0, mor0, 16, c, w, r, d);
      step(mq1, mov1, mud1, mor1, 10, c, w, r, d);
      sb0.push_back(mk(mq0, mov0, mud0, mor0, 16, 14, 2));
      sb1.push_back(mk(mq1, mov1, mud1, mor1, 10, 8, 3));
   endtask

   task automatic wr(input logic [7:0] d); cyc(0, 1, 0, d); endtask
   task automatic rd();                    cyc(0, 0, 1, 8'h00); endtask

   task automatic check_now(input string tag);
      cmp({tag, "16"}, mk(mq0, mov0, mud0, mor0, 16, 14, 2), d0, c0, f0, e0, af0, ae0, ov0, ud0);
      cmp({tag, "10"}, mk(mq1, mov1, mud1, mor1, 10, 8, 3),  d1, c1, f1, e1, af1, ae1, ov1, ud1);
   endtask

   // Drop reset between edges and check that everything returns without a clock.
   task automatic async_reset();
      @(negedge clk);
      clear = 0; wr_en = 0; rd_en = 0;
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_now("rst");
      @(negedge clk);
      check_now("rsthold");
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      #1;
      if (sb0.size() != 0) begin
         x0 = sb0.pop_front();
         cmp("m16", x0, d0, c0, f0, e0, af0, ae0, ov0, ud0);
      end
      if (sb1.size() != 0) begin
         x1 = sb1.pop_front();
         cmp("m10", x1, d1, c1, f1, e1, af1, ae1, ov1, ud1);
      end
   end

   initial begin
      int n;
      int wp, rp;
      model_reset();
      #3 check_now("init");
      @(negedge clk);
      rst_n = 1'b1;

      // basic write/read
      wr(8'hA5); wr(8'h5A); rd(); rd();

      // fill past full, then drain
      for (int i = 0; i < 16; i++) wr(8'(i));
      wr(8'hEE);
      for (int i = 0; i < 16; i++) rd();
      cyc(1, 0, 0, 8'h00);

      // simultaneous read/write while full
      for (int i = 0; i < 16; i++) wr(8'(i));
      cyc(0, 1, 1, 8'hFF);
      for (int i = 0; i < 16; i++) rd();

      // simultaneous read/write while empty
      cyc(0, 1, 1, 8'h3C);
      rd();

      // bursts of 7 through the 10-deep instance to exercise wrap
      n = 0;
      while (n < 25) begin
         int b = (25 - n < 7) ? 25 - n : 7;
         for (int i = 0; i < b; i++) wr(8'(8'h40 + n + i));
         for (int i = 0; i < b; i++) rd();
         n += b;
      end
      for (int i = 0; i < 5; i++) wr(8'(8'h80 + i));
      cyc(1, 1, 1, 8'h99);
      rd();

      // randomized traffic with varying write/read pressure
      for (int seg = 0; seg < 4; seg++) begin
         wp = (seg == 0) ? 80 : (seg == 1) ? 25 : 55;
         rp = (seg == 0) ? 30 : (seg == 1) ? 80 : 50;
         for (int i = 0; i < 120; i++)
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < wp),
                ($urandom_range(0, 99) < rp), 8'($urandom));
      end

      // reset mid-burst with 5 entries held
      cyc(1, 0, 0, 8'h00);
      for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i));
      async_reset();
      wr(8'hA5); wr(8'h5A); rd(); rd();

      @(posedge clk);
      #3;
      chk("sb_drained", 32'(sb0.size() + sb1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
